mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin and 1 = port 1 (D-cache) always wins a tie.
REQ-002 SHALL have port clk_i, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have ports p0_enable_i, p0_write_i, input, 1 each, for the I-cache request and write flag.
REQ-005 SHALL have ports p0_addr_i, input, 32, and p0_data_i, input, 256, for the I-cache address and write line.
REQ-006 SHALL have ports p0_data_o, output, 256, and p0_ack_o, output, 1, for the I-cache read line and completion.
REQ-007 SHALL have ports p1_enable_i, p1_write_i, p1_addr_i[31:0], p1_data_i[255:0], p1_data_o[255:0], p1_ack_o, identical in meaning for the D-cache.
REQ-008 SHALL have outputs mem_enable_o (1), mem_write_o (1), mem_addr_o (32) and mem_data_o (256) to data memory.
REQ-009 SHALL have inputs mem_data_i (256) and mem_ack_i (1) from data memory.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 IDLE: if any pN_enable_i=1, SHALL pick the winner, latch its addr/write/data into registers, set grant and enter BUSY; otherwise it stays in IDLE.
REQ-012 Tie, FIXED_PRIO=0: SHALL grant the port not granted last (last_grant register); with FIXED_PRIO=1, port 1 wins.
REQ-013 Single requester: SHALL grant it regardless of last_grant.
REQ-014 BUSY: mem_enable_o SHALL be 1, registered (first high cycle = first BUSY cycle).
REQ-015 BUSY: mem_addr_o, mem_write_o and mem_data_o SHALL come from the latched registers, stable for the whole transaction even if requester inputs change.
REQ-016 BUSY with mem_ack_i=1: SHALL assert pG_ack_o=1 combinationally in the same cycle for the granted port only, update last_grant, and enter DONE.
REQ-017 pG_data_o SHALL equal mem_data_i whenever port G is granted; the non-granted port's data_o and ack_o SHALL be 0.
REQ-018 DONE: SHALL drive mem_enable_o=0 for exactly one cycle, ignore all requests, and return to IDLE; this guarantees a one-cycle enable gap between transactions.
REQ-019 mem_ack_i SHALL be ignored in IDLE and DONE; a stray ack never produces pN_ack_o.
REQ-020 A requester that keeps enable high after its ack SHALL be treated as a new request in the next IDLE cycle.
REQ-021 mem_write_o SHALL be 0 and mem_addr_o/mem_data_o SHALL be 0 outside BUSY.
REQ-022 No timeout: BUSY SHALL persist indefinitely until mem_ack_i.
REQ-023 Round-trip from request to ack is 1 (IDLE) + memory latency cycles; back-to-back requests are issued every latency+2 cycles.

Reset
REQ-024 On rst_i=0 at a clock edge: state=IDLE, grant cleared, last_grant=1 (port 0 wins the first tie), latched regs=0, mem_enable_o=0, mem_write_o=0, both ack_o=0.
REQ-025 Reset asserted mid-BUSY SHALL abort the transaction: mem_enable_o=0 on the next cycle with no ack to either port; a later mem_ack_i is ignored.

Verification
REQ-026 SHALL cover single read: p0 read addr 0x00000400, memory acks 10 cycles later with line 0xA5..A5 -> p0_ack_o=1 for one cycle, p0_data_o=0xA5..A5, p1_ack_o=0, mem_enable_o low the following cycle.
REQ-027 SHALL cover simultaneous requests after reset (p0 read 0x100, p1 write 0x200): p0 is served first, p1 next; mem_addr_o goes 0x100 then 0x200 with a one-cycle enable gap between.
REQ-028 SHALL cover both requesters held high for 4 transactions with FIXED_PRIO=0: grants alternate 0,1,0,1; with FIXED_PRIO=1: grants are 1,1,1,1.
REQ-029 SHALL cover a requester changing p1_addr_i and p1_data_i mid-BUSY: mem_addr_o and mem_data_o keep their latched values until ack.
REQ-030 SHALL cover reset asserted 3 cycles into BUSY followed by a late mem_ack_i: no pN_ack_o, state IDLE, mem_enable_o=0.
REQ-031 SHALL cover mem_ack_i pulsed in IDLE: no ack output and no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single data-memory port. Port 0 is the
// I-cache, port 1 the D-cache. One transaction is in flight at a time; the
// winner's address, write flag and write line are captured on grant so the
// memory side sees stable values for the whole transaction.
//
// Parameters
//   FIXED_PRIO  0 = round-robin on a tie, 1 = port 1 always wins a tie
//
// Ports
//   clk_i                 system clock, rising edge
//   rst_i                 synchronous reset, active low
//   p0_enable_i/p1_*      request valid
//   p0_write_i/p1_*       1 = write, 0 = read
//   p0_addr_i/p1_*        32-bit line address
//   p0_data_i/p1_*        256-bit write line
//   p0_data_o/p1_*        256-bit read line (mem_data_i while granted, else 0)
//   p0_ack_o/p1_*         completion, combinational from mem_ack_i in BUSY
//   mem_enable_o          registered, high for every BUSY cycle
//   mem_write_o           latched write flag (0 outside BUSY)
//   mem_addr_o            latched address (0 outside BUSY)
//   mem_data_o            latched write line (0 outside BUSY)
//   mem_data_i            read line from memory
//   mem_ack_i             memory completion, only honoured in BUSY
//
// States
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; picks a winner and latches its request
//   BUSY  | mem_enable_o high, waiting (without timeout) for mem_ack_i
//   DONE  | one-cycle enable gap; all requests and acks ignored
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         p0_enable_i,
    input  logic         p0_write_i,
    input  logic [31:0]  p0_addr_i,
    input  logic [255:0] p0_data_i,
    output logic [255:0] p0_data_o,
    output logic         p0_ack_o,

    input  logic         p1_enable_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [255:0] p1_data_i,
    output logic [255:0] p1_data_o,
    output logic         p1_ack_o,

    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     grant_q, grant_d;      // one-hot, bit N = port N owns memory
    logic           last_grant_q, last_grant_d;
    logic [31:0]    addr_q, addr_d;
    logic           write_q, write_d;
    logic [255:0]   data_q, data_d;
    logic           enable_q, enable_d;

    logic           any_req;
    logic           tie;
    logic           pick_p1;
    logic           busy;

    // Winner selection. A lone requester always wins; on a tie either the
    // fixed priority applies or the port that did not win last time.
    always_comb begin
        any_req = p0_enable_i | p1_enable_i;
        tie     = p0_enable_i & p1_enable_i;
        if (tie) begin
            if (FIXED_PRIO != 0) begin
                pick_p1 = 1'b1;
            end else begin
                pick_p1 = ~last_grant_q;
            end
        end else begin
            pick_p1 = p1_enable_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        data_d       = data_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    if (pick_p1) begin
                        grant_d = 2'b10;
                        addr_d  = p1_addr_i;
                        write_d = p1_write_i;
                        data_d  = p1_data_i;
                    end else begin
                        grant_d = 2'b01;
                        addr_d  = p0_addr_i;
                        write_d = p0_write_i;
                        data_d  = p0_data_i;
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d      = DONE;
                    last_grant_d = grant_q[1];
                    grant_d      = 2'b00;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase

        // Enable is a flop so it rises on the first BUSY cycle, not earlier.
        enable_d = (state_d == BUSY);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;       // makes port 0 win the first tie
            addr_q       <= '0;
            write_q      <= 1'b0;
            data_q       <= '0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            data_q       <= data_d;
            enable_q     <= enable_d;
        end
    end

    assign busy = (state_q == BUSY);

    // Memory-side request: latched values, forced to zero outside BUSY.
    assign mem_enable_o = enable_q;
    assign mem_write_o  = busy & write_q;
    assign mem_addr_o   = busy ? addr_q : '0;
    assign mem_data_o   = busy ? data_q : '0;

    // Completion passes straight through for the granted port only; an ack
    // seen in IDLE or DONE never reaches a requester.
    assign p0_ack_o  = busy & grant_q[0] & mem_ack_i;
    assign p1_ack_o  = busy & grant_q[1] & mem_ack_i;
    assign p0_data_o = grant_q[0] ? mem_data_i : '0;
    assign p1_data_o = grant_q[1] ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Two instances share all inputs: one
// round-robin, one fixed-priority. Expected transactions are queued when the
// requests are driven and popped when the memory acknowledges.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p0_enable_i, p0_write_i;
    logic [31:0]  p0_addr_i;
    logic [255:0] p0_data_i;
    logic         p1_enable_i, p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [255:0] p1_data_i;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    logic [255:0] p0_data_o, p1_data_o, mem_data_o;
    logic         p0_ack_o, p1_ack_o, mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;

    logic [255:0] fp_p0_data_o, fp_p1_data_o, fp_mem_data_o;
    logic         fp_p0_ack_o, fp_p1_ack_o, fp_mem_enable_o, fp_mem_write_o;
    logic [31:0]  fp_mem_addr_o;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_data_o(fp_p0_data_o), .p0_ack_o(fp_p0_ack_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(fp_p1_data_o), .p1_ack_o(fp_p1_ack_o),
        .mem_enable_o(fp_mem_enable_o), .mem_write_o(fp_mem_write_o), .mem_addr_o(fp_mem_addr_o),
        .mem_data_o(fp_mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    typedef struct {
        logic         port;      // expected winner, round-robin instance
        logic         fp_port;   // expected winner, fixed-priority instance
        logic [31:0]  addr;
        logic         write;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } txn_t;

    txn_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plays the memory for the oldest queued transaction: waits for enable,
    // checks the latched request, acks in BUSY cycle 'lat', checks the gap.
    task automatic serve(input int lat, input logic [1:0] drop, input bit scramble, input string tag);
        txn_t t;
        int   n;
        t = sb.pop_front();
        n = 0;
        @(negedge clk_i);
        while (mem_enable_o !== 1'b1 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_enable"}, mem_enable_o, 1'b1);
        check({tag, "_addr"},   mem_addr_o,   t.addr);
        check({tag, "_write"},  mem_write_o,  t.write);
        check({tag, "_wdata"},  mem_data_o,   t.wdata);
        if (drop[0]) p0_enable_i = 1'b0;
        if (drop[1]) p1_enable_i = 1'b0;
        if (scramble) begin
            p1_addr_i = 32'hDEAD_BEEF;
            p1_data_i = {8{32'h0BAD_F00D}};
            p0_addr_i = 32'hFEED_0000;
        end
        repeat (lat - 1) @(posedge clk_i);
        #1;
        mem_ack_i  = 1'b1;
        mem_data_i = t.rdata;
        @(negedge clk_i);
        check({tag, "_ack0"},    p0_ack_o,    t.port == 1'b0);
        check({tag, "_ack1"},    p1_ack_o,    t.port == 1'b1);
        check({tag, "_rdata0"},  p0_data_o,   (t.port == 1'b0) ? t.rdata : 256'd0);
        check({tag, "_rdata1"},  p1_data_o,   (t.port == 1'b1) ? t.rdata : 256'd0);
        check({tag, "_addr_hold"},  mem_addr_o, t.addr);
        check({tag, "_wdata_hold"}, mem_data_o, t.wdata);
        check({tag, "_fp_ack0"}, fp_p0_ack_o, t.fp_port == 1'b0);
        check({tag, "_fp_ack1"}, fp_p1_ack_o, t.fp_port == 1'b1);
        @(posedge clk_i);
        #1;
        mem_ack_i  = 1'b0;
        mem_data_i = {8{32'h5A5A_0F0F}};
        @(negedge clk_i);
        check({tag, "_gap_enable"}, mem_enable_o, 1'b0);
        check({tag, "_gap_ack"},    {p0_ack_o, p1_ack_o}, 2'b00);
        check({tag, "_gap_addr"},   mem_addr_o, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b0;
        p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
        p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        mem_ack_i   = 1'b0; mem_data_i = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_enable", mem_enable_o, 1'b0);
        check("rst_write",  mem_write_o,  1'b0);
        check("rst_addr",   mem_addr_o,   32'd0);
        check("rst_acks",   {p0_ack_o, p1_ack_o, fp_p0_ack_o, fp_p1_ack_o}, 4'b0000);

        // Simultaneous requests right after reset: p0 first, then p1
        @(posedge clk_i); #1;
        p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h100; p0_data_i = {8{32'h0000_1111}};
        p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h200; p1_data_i = {8{32'hCAFE_0001}};
        sb.push_back('{1'b0, 1'b1, 32'h100, 1'b0, {8{32'h0000_1111}}, {8{32'h1357_9BDF}}});
        sb.push_back('{1'b1, 1'b1, 32'h200, 1'b1, {8{32'hCAFE_0001}}, {8{32'h2468_ACE0}}});
        serve(3, 2'b01, 1'b0, "sim_a");
        serve(3, 2'b10, 1'b0, "sim_b");

        // Single read, 10-cycle memory latency
        @(posedge clk_i); #1;
        p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h0000_0400; p0_data_i = '0;
        sb.push_back('{1'b0, 1'b0, 32'h0000_0400, 1'b0, 256'd0, {32{8'hA5}}});
        serve(10, 2'b01, 1'b0, "single");

        // Requester changes address and data mid-BUSY
        @(posedge clk_i); #1;
        p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h300; p1_data_i = {8{32'h1234_5678}};
        sb.push_back('{1'b1, 1'b1, 32'h300, 1'b1, {8{32'h1234_5678}}, {8{32'h0000_00FF}}});
        serve(5, 2'b10, 1'b1, "midbusy");

        // Both held high for four transactions: rr 0,1,0,1 and fp 1,1,1,1
        @(posedge clk_i); #1;
        p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h10; p0_data_i = {8{32'hAAAA_0000}};
        p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h20; p1_data_i = {8{32'hBBBB_0000}};
        sb.push_back('{1'b0, 1'b1, 32'h10, 1'b0, {8{32'hAAAA_0000}}, {8{32'h0000_0001}}});
        sb.push_back('{1'b1, 1'b1, 32'h20, 1'b1, {8{32'hBBBB_0000}}, {8{32'h0000_0002}}});
        sb.push_back('{1'b0, 1'b1, 32'h10, 1'b0, {8{32'hAAAA_0000}}, {8{32'h0000_0003}}});
        sb.push_back('{1'b1, 1'b1, 32'h20, 1'b1, {8{32'hBBBB_0000}}, {8{32'h0000_0004}}});
        serve(2, 2'b00, 1'b0, "hold_t0");
        serve(2, 2'b00, 1'b0, "hold_t1");
        serve(2, 2'b00, 1'b0, "hold_t2");
        serve(2, 2'b11, 1'b0, "hold_t3");

        // Reset three cycles into BUSY, then a late ack
        @(posedge clk_i); #1;
        p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h500;
        begin
            int n;
            n = 0;
            @(negedge clk_i);
            while (mem_enable_o !== 1'b1 && n < 40) begin
                @(negedge clk_i);
                n++;
            end
            check("abort_enable", mem_enable_o, 1'b1);
        end
        p0_enable_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_enable_low", {mem_enable_o, fp_mem_enable_o}, 2'b00);
        check("abort_acks", {p0_ack_o, p1_ack_o, fp_p0_ack_o, fp_p1_ack_o}, 4'b0000);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b1; mem_data_i = {8{32'h7777_7777}};
        @(negedge clk_i);
        check("late_ack_acks",  {p0_ack_o, p1_ack_o, fp_p0_ack_o, fp_p1_ack_o}, 4'b0000);
        check("late_ack_data0", p0_data_o, 256'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("late_ack_idle_enable", mem_enable_o, 1'b0);
        check("late_ack_idle_addr",   mem_addr_o,   32'd0);

        // Stray ack in IDLE with no requests
        @(posedge clk_i); #1;
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        check("stray_acks",  {p0_ack_o, p1_ack_o}, 2'b00);
        check("stray_data1", p1_data_o, 256'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("stray_enable", {mem_enable_o, fp_mem_enable_o}, 2'b00);

        // Tie after the abort reset: last_grant restarts so p0 wins again
        @(posedge clk_i); #1;
        p0_enable_i = 1'b1; p0_write_i = 1'b1; p0_addr_i = 32'h600; p0_data_i = {8{32'h6666_0000}};
        p1_enable_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h700; p1_data_i = '0;
        sb.push_back('{1'b0, 1'b1, 32'h600, 1'b1, {8{32'h6666_0000}}, {8{32'h0000_0ABC}}});
        serve(4, 2'b11, 1'b0, "post_rst_tie");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
